// File: rtl/board_input_store.sv
// board_input_store
// Debounces the four active-low move keys into a one-hot direction command
// (one command per press, no auto-repeat) and holds the 16-tile board that is
// loaded from the game controller.
// Optional feature macro: MAX_TILE_EN adds a registered max_tile output that
// tracks the largest tile exponent currently on the board.
module board_input_store #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [7:0]  DIR_HOLD        = 8'd16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  key_n,
    input  logic        update,
    input  logic [63:0] newvalues,
    output logic [63:0] oldvalues,
    output logic [3:0]  direction,
    output logic        busy,
    output logic [15:0] moves
`ifdef MAX_TILE_EN
    ,
    output logic [3:0]  max_tile
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // reset and new-game share the same clearing effect
    logic clear;
    assign clear = !reset_n || start;

    logic [3:0]  sync1_reg;
    logic [3:0]  sync2_reg;
    logic [3:0]  pressed_sync;
    logic [3:0]  accepted;
    logic [3:0]  accepted_prev_reg;
    logic [3:0]  rise;
    logic        single_key;
    state_t      state_reg;
    logic [7:0]  hold_cnt_reg;
    logic [3:0]  direction_reg;
    logic        busy_reg;
    logic [15:0] moves_reg;
    logic [63:0] board_reg;

    // two-flop synchroniser on the raw buttons; idle level is released (1)
    always_ff @(posedge clock) begin
        if (clear) begin
            sync1_reg <= 4'hF;
            sync2_reg <= 4'hF;
        end else begin
            sync1_reg <= key_n;
            sync2_reg <= sync1_reg;
        end
    end

    assign pressed_sync = ~sync2_reg;

    // one debounce counter per key; the accepted level only flips after the
    // synced level has disagreed with it for DEBOUNCE_CYCLES samples in a row
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
            logic [15:0] cnt_reg;
            logic        level_reg;

            // count consecutive disagreeing samples, flip the level when full
            always_ff @(posedge clock) begin
                if (clear) begin
                    cnt_reg   <= 16'd0;
                    level_reg <= 1'b0;
                end else if (pressed_sync[gi] != level_reg) begin
                    if (cnt_reg == DEBOUNCE_CYCLES - 16'd1) begin
                        level_reg <= ~level_reg;
                        cnt_reg   <= 16'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end else begin
                    cnt_reg <= 16'd0;
                end
            end

            assign accepted[gi] = level_reg;
        end
    endgenerate

    // previous accepted levels, used for press (rising edge) detection
    always_ff @(posedge clock) begin
        if (clear) begin
            accepted_prev_reg <= 4'h0;
        end else begin
            accepted_prev_reg <= accepted;
        end
    end

    assign rise       = accepted & ~accepted_prev_reg;
    // a press only counts as a move when it is the only key held
    assign single_key = (accepted != 4'h0) && ((accepted & (accepted - 4'd1)) == 4'h0);

    // command FSM: issue one command per single-key press, then wait for all keys up
    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg     <= IDLE;
            hold_cnt_reg  <= 8'd0;
            direction_reg <= 4'h0;
            busy_reg      <= 1'b0;
            moves_reg     <= 16'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    direction_reg <= 4'h0;
                    if (rise != 4'h0) begin
                        busy_reg <= 1'b1;
                        if (single_key) begin
                            state_reg     <= HOLD;
                            hold_cnt_reg  <= 8'd0;
                            direction_reg <= accepted;
                            moves_reg     <= moves_reg + 16'd1;
                        end else begin
                            state_reg <= RELEASE;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt_reg == DIR_HOLD - 8'd1) begin
                        direction_reg <= 4'h0;
                        state_reg     <= RELEASE;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 8'd1;
                    end
                end
                RELEASE: begin
                    direction_reg <= 4'h0;
                    if (accepted == 4'h0) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    direction_reg <= 4'h0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    // board register: new game clears it, otherwise load on update
    always_ff @(posedge clock) begin
        if (clear) begin
            board_reg <= 64'h0;
        end else if (update) begin
            board_reg <= newvalues;
        end
    end

    assign oldvalues = board_reg;
    assign direction = direction_reg;
    assign busy      = busy_reg;
    assign moves     = moves_reg;

`ifdef MAX_TILE_EN
    logic [3:0] max_tile_next;
    logic [3:0] max_tile_reg;

    // largest exponent over the currently held board
    always_comb begin
        max_tile_next = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (board_reg[i*4 +: 4] > max_tile_next) begin
                max_tile_next = board_reg[i*4 +: 4];
            end
        end
    end

    // register the maximum so it follows a load by one cycle
    always_ff @(posedge clock) begin
        if (clear) begin
            max_tile_reg <= 4'h0;
        end else begin
            max_tile_reg <= max_tile_next;
        end
    end

    assign max_tile = max_tile_reg;
`endif

endmodule
